// File: rtl/fft_stage_sequencer.sv
// Control sequencer for a radix-2 in-place FFT: walks every stage,
// issues butterfly addresses/twiddles and delays them into write strobes.
module fft_stage_sequencer #(
    parameter int N      = 64,
    parameter int LOG2N  = 6,
    parameter int BF_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bf_ready,
    output logic             bf_valid,
    output logic [2:0]       stage,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(BF_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LOG2N-2:0] K_LAST   = '1;
    localparam logic [LOG2N-2:0] K_ONE    = (LOG2N-1)'(1);
    localparam logic [2:0]       STG_LAST = 3'(LOG2N - 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(BF_LAT);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [LOG2N-1:0] A_ONE    = LOG2N'(1);

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [2:0]       stage_d;
    logic [LOG2N-2:0] k;
    logic [LOG2N-2:0] k_d;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_d;
    logic             bfv_d;
    logic             ld;
    logic             hs;

    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [2:0]       tw_sh;
    logic [LOG2N-1:0] a_nxt;
    logic [LOG2N-1:0] b_nxt;
    logic [LOG2N-2:0] t_nxt;

    logic             dl_v [BF_LAT];
    logic [LOG2N-1:0] dl_a [BF_LAT];
    logic [LOG2N-1:0] dl_b [BF_LAT];

    assign hs   = bf_valid && bf_ready;
    assign busy = (state == S_ISSUE) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    assign wr_en     = dl_v[BF_LAT-1];
    assign wr_addr_a = dl_a[BF_LAT-1];
    assign wr_addr_b = dl_b[BF_LAT-1];

    // Addresses for the butterfly that will be presented next cycle.
    always_comb begin
        span  = A_ONE << stage_d;
        pos   = {1'b0, k_d} & (span - A_ONE);
        grp   = {1'b0, k_d} >> stage_d;
        a_nxt = ((grp << stage_d) << 1) | pos;
        b_nxt = a_nxt + span;
        tw_sh = STG_LAST - stage_d;
        t_nxt = pos[LOG2N-2:0] << tw_sh;
    end

    always_comb begin
        state_d = state;
        stage_d = stage;
        k_d     = k;
        cnt_d   = cnt;
        bfv_d   = bf_valid;
        ld      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    stage_d = 3'd0;
                    k_d     = '0;
                    bfv_d   = 1'b1;
                    ld      = 1'b1;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    if (k == K_LAST) begin
                        state_d = S_DRAIN;
                        bfv_d   = 1'b0;
                        cnt_d   = CNT_INIT;
                    end else begin
                        k_d = k + K_ONE;
                        ld  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_ONE) begin
                    if (stage != STG_LAST) begin
                        state_d = S_ISSUE;
                        stage_d = stage + 3'd1;
                        k_d     = '0;
                        bfv_d   = 1'b1;
                        ld      = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            stage    <= 3'd0;
            k        <= '0;
            cnt      <= '0;
            bf_valid <= 1'b0;
            addr_a   <= '0;
            addr_b   <= '0;
            tw_idx   <= '0;
        end else begin
            state    <= state_d;
            stage    <= stage_d;
            k        <= k_d;
            cnt      <= cnt_d;
            bf_valid <= bfv_d;
            if (ld) begin
                addr_a <= a_nxt;
                addr_b <= b_nxt;
                tw_idx <= t_nxt;
            end
        end
    end

    // Write-back delay line free-runs so stalls never hold back results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BF_LAT; i++) begin
                dl_v[i] <= 1'b0;
                dl_a[i] <= '0;
                dl_b[i] <= '0;
            end
        end else begin
            dl_v[0] <= hs;
            dl_a[0] <= addr_a;
            dl_b[0] <= addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomized bench for fft_stage_sequencer against a butterfly-order
// reference list built from plain arithmetic.
module tb_fft_stage_sequencer;

    localparam int N      = 64;
    localparam int LOG2N  = 6;
    localparam int BF_LAT = 2;
    localparam int NB     = N / 2;
    localparam int TOTAL  = LOG2N * NB;
    localparam int BUSY_LEN = LOG2N * (NB + BF_LAT);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             bf_ready = 1'b0;
    logic             bf_valid;
    logic [2:0]       stage;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    int ex_s [TOTAL];
    int ex_a [TOTAL];
    int ex_b [TOTAL];
    int ex_t [TOTAL];
    int obs_a [TOTAL];
    int obs_b [TOTAL];
    int obs_t [TOTAL];
    int n_iss;
    int n_wr;
    int done_cyc;
    int wq_a [$];
    int wq_b [$];
    int wq_d [$];

    fft_stage_sequencer #(.N(N), .LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .bf_ready(bf_ready),
        .bf_valid(bf_valid), .stage(stage), .addr_a(addr_a),
        .addr_b(addr_b), .tw_idx(tw_idx), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bf_valid"}, 32'(bf_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_stage"}, 32'(stage), 0);
        chk({tag, "_addr_a"}, 32'(addr_a), 0);
        chk({tag, "_addr_b"}, 32'(addr_b), 0);
        chk({tag, "_tw_idx"}, 32'(tw_idx), 0);
        chk({tag, "_wr_addr_a"}, 32'(wr_addr_a), 0);
        chk({tag, "_wr_addr_b"}, 32'(wr_addr_b), 0);
    endtask

    // Butterfly k of stage s pairs the element at offset k%span of group
    // k/span with its partner span positions higher.
    task automatic build_model();
        int i = 0;
        for (int s = 0; s < LOG2N; s++) begin
            int span = 2 ** s;
            for (int kk = 0; kk < NB; kk++) begin
                ex_s[i] = s;
                ex_a[i] = (kk / span) * 2 * span + (kk % span);
                ex_b[i] = ex_a[i] + span;
                ex_t[i] = (kk % span) * (NB / span);
                i++;
            end
        end
    endtask

    task automatic run(input bit bp, input int abort_at, input bit poke);
        int c;
        bit hs;
        bit stalled;
        bit aborted;
        logic [31:0] pa, pb, pt, ps;
        int seen [LOG2N][N];
        for (int s = 0; s < LOG2N; s++)
            for (int a = 0; a < N; a++)
                seen[s][a] = 0;
        n_iss = 0;
        n_wr = 0;
        done_cyc = 0;
        wq_a.delete();
        wq_b.delete();
        wq_d.delete();
        stalled = 0;
        aborted = 0;
        pa = 0; pb = 0; pt = 0; ps = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c < 3000) begin
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                chk_zero("abort_rst");
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_wr_en", 32'(wr_en), 0);
                end
                rst = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("abort_idle_busy", 32'(busy), 0);
                end
                aborted = 1;
                break;
            end
            if (stalled) begin
                chk("stall_valid", 32'(bf_valid), 1);
                chk("stall_addr_a", 32'(addr_a), pa);
                chk("stall_addr_b", 32'(addr_b), pb);
                chk("stall_tw", 32'(tw_idx), pt);
                chk("stall_stage", 32'(stage), ps);
            end
            bf_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = bf_valid && bf_ready;
            if (hs) begin
                if (n_iss < TOTAL) begin
                    chk("iss_stage", 32'(stage), ex_s[n_iss]);
                    chk("iss_addr_a", 32'(addr_a), ex_a[n_iss]);
                    chk("iss_addr_b", 32'(addr_b), ex_b[n_iss]);
                    chk("iss_tw", 32'(tw_idx), ex_t[n_iss]);
                    obs_a[n_iss] = int'(addr_a);
                    obs_b[n_iss] = int'(addr_b);
                    obs_t[n_iss] = int'(tw_idx);
                    if (stage < LOG2N) begin
                        seen[stage][addr_a]++;
                        seen[stage][addr_b]++;
                    end
                end else begin
                    chk("extra_issue", n_iss, TOTAL - 1);
                end
                wq_a.push_back(int'(addr_a));
                wq_b.push_back(int'(addr_b));
                wq_d.push_back(c + BF_LAT);
                n_iss++;
            end
            stalled = bf_valid && !hs;
            pa = 32'(addr_a);
            pb = 32'(addr_b);
            pt = 32'(tw_idx);
            ps = 32'(stage);
            if (wr_en) begin
                if (wq_d.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    chk("wr_cycle", c, wq_d.pop_front());
                    chk("wr_addr_a", 32'(wr_addr_a), wq_a.pop_front());
                    chk("wr_addr_b", 32'(wr_addr_b), wq_b.pop_front());
                end
                n_wr++;
            end
            if (!bp) chk("busy", 32'(busy), 32'(c <= BUSY_LEN));
            if (poke && c == 50) start = 1'b1;
            if (poke && c == 51) start = 1'b0;
            if (done) begin
                done_cyc = c;
                if (poke) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("done_pulse", 32'(done), 0);
                repeat (6) begin
                    chk("post_busy", 32'(busy), 0);
                    chk("post_valid", 32'(bf_valid), 0);
                    @(negedge clk);
                end
                break;
            end
            @(negedge clk);
            c++;
        end
        if (!aborted) begin
            chk("done_seen", 32'(done_cyc != 0), 1);
            chk("n_issue", n_iss, TOTAL);
            chk("n_write", n_wr, TOTAL);
            chk("wq_left", wq_d.size(), 0);
            if (!bp) chk("done_cycle", done_cyc, BUSY_LEN + 1);
            for (int s = 0; s < LOG2N; s++) begin
                int ok = 1;
                for (int a = 0; a < N; a++)
                    if (seen[s][a] != 1) ok = 0;
                chk($sformatf("cover_stage%0d", s), ok, 1);
            end
        end
    endtask

    initial begin
        build_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_valid", 32'(bf_valid), 0);
        end

        run(1'b0, 0, 1'b0);
        chk("s0_k0_a", obs_a[0], 0);
        chk("s0_k0_b", obs_b[0], 1);
        chk("s0_k0_tw", obs_t[0], 0);
        chk("s0_k1_a", obs_a[1], 2);
        chk("s0_k1_b", obs_b[1], 3);
        chk("s0_k1_tw", obs_t[1], 0);
        chk("s5_k1_a", obs_a[5*NB+1], 1);
        chk("s5_k1_b", obs_b[5*NB+1], 33);
        chk("s5_k1_tw", obs_t[5*NB+1], 1);
        chk("s5_k31_a", obs_a[5*NB+31], 31);
        chk("s5_k31_b", obs_b[5*NB+31], 63);
        chk("s5_k31_tw", obs_t[5*NB+31], 31);

        run(1'b1, 0, 1'b0);
        run(1'b0, 0, 1'b1);
        run(1'b0, 100, 1'b0);
        run(1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
